multi_cycle_controller: RTL and testbench

Control FSM that sequences the multi-cycle RISC-V datapath: one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives every datapath enable and mux select from the current state, the decoded instruction fields, and the ALU flags. It sits beside the datapath at the CPU top level and also generates the memory write strobe.

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/alu_decoder.sv | 40 ++++
 rtl/multi_cycle_controller.sv | 149 ++++++++++++++
 tb/tb_multi_cycle_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: states, opcodes and datapath select encodings for the multi-cycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI
    } state_t;

    typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BR} alu_class_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        return op == OP_SW  ? IMM_S :
               op == OP_BR  ? IMM_B :
               op == OP_LUI ? IMM_U :
               op == OP_JAL ? IMM_J : IMM_I;
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps instruction class and func fields to an ALU operation and a legality flag
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_class_t  cls,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output logic [2:0]  alu_ctrl,
    output logic        legal
);

    // R/I share the func3 table; only R uses func7 (sub, and rejects any other func7)
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (cls)
            CLS_R, CLS_I: begin
                case (func3)
                    3'b000:  alu_ctrl = (cls == CLS_R && func7[5]) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_ctrl = ALU_AND;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b010:  alu_ctrl = ALU_SLT;
                    default: legal = 1'b0;
                endcase
                if (cls == CLS_R && !(func7 == 7'b0000000 || (func7 == 7'b0100000 && func3 == 3'b000)))
                    legal = 1'b0;
            end
            CLS_BR: begin
                case (func3)
                    3'b000, 3'b001: alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl = ALU_SLT;
                    default:        legal = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: control FSM sequencing the multi-cycle RISC-V datapath
module multi_cycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       LSB,
    output logic       PCWrite,
    output logic       adrSrc,
    output logic       IRWrite,
    output logic       regWrite,
    output logic       memWrite,
    output logic [2:0] ALUControl,
    output logic [2:0] immSrc,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       illegal
);

    state_t     state;
    alu_class_t cls;
    logic [2:0] alu_ctrl;
    logic       legal;
    logic       ok;

    assign cls = op == OP_R  ? CLS_R  :
                 op == OP_I  ? CLS_I  :
                 op == OP_BR ? CLS_BR : CLS_ADD;
    assign ok  = known_op(op) && legal;

    alu_decoder u_alu_decoder (
        .cls      (cls),
        .func3    (func3),
        .func7    (func7),
        .alu_ctrl (alu_ctrl),
        .legal    (legal)
    );

    // State sequencing; DECODE dispatches on opcode, illegal encodings go straight back to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else begin
            case (state)
                S_INIT:   state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (!ok) state <= S_FETCH;
                    else begin
                        case (op)
                            OP_LW, OP_SW: state <= S_MEMADR;
                            OP_R:         state <= S_EXECR;
                            OP_I:         state <= S_EXECI;
                            OP_BR:        state <= S_BRANCH;
                            OP_JAL:       state <= S_JAL;
                            OP_JALR:      state <= S_JALR;
                            default:      state <= S_LUI;
                        endcase
                    end
                end
                S_MEMADR:             state <= op == OP_LW ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:            state <= S_MEMWB;
                S_EXECR, S_EXECI:     state <= S_ALUWB;
                S_JAL, S_JALR:        state <= S_LINK;
                S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LINK, S_LUI: state <= S_FETCH;
                default:              state <= S_INIT;
            endcase
        end
    end

    // Datapath controls from the current state; only BRANCH's PCWrite looks at the ALU flags
    always_comb begin
        PCWrite    = 1'b0;
        adrSrc     = 1'b0;
        IRWrite    = 1'b0;
        regWrite   = 1'b0;
        memWrite   = 1'b0;
        ALUControl = ALU_ADD;
        immSrc     = state == S_INIT ? IMM_I : imm_sel(op);
        resultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_4;
                resultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                illegal = !ok;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
                resultSrc = RES_DATA;
                regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                ALUControl = alu_ctrl;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_ctrl;
            end
            S_ALUWB: regWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUControl = alu_ctrl;
                PCWrite    = func3[2] ? (LSB ^ func3[0]) : (zero ^ func3[0]);
            end
            S_JAL: PCWrite = 1'b1;
            S_JALR: begin
                ALUSrcA   = SRCA_A;
                ALUSrcB   = SRCB_IMM;
                resultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_LINK: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_4;
                resultSrc = RES_ALURESULT;
                regWrite  = 1'b1;
            end
            S_LUI: begin
                resultSrc = RES_IMM;
                regWrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: instruction-level model of the controller checked every cycle
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       LSB;
    logic       PCWrite, adrSrc, IRWrite, regWrite, memWrite, illegal;
    logic [2:0] ALUControl, immSrc;
    logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
    logic [17:0] got;

    int checks = 0;
    int failures = 0;

    localparam logic [17:0] PCW = 18'h20000;
    localparam logic [17:0] ADR = 18'h10000;
    localparam logic [17:0] IRW = 18'h08000;
    localparam logic [17:0] RW  = 18'h04000;
    localparam logic [17:0] MW  = 18'h02000;
    localparam logic [17:0] ALU = 18'h01C00;
    localparam logic [17:0] IMM = 18'h00380;
    localparam logic [17:0] RES = 18'h00060;
    localparam logic [17:0] SB  = 18'h00006;
    localparam logic [17:0] ILL = 18'h00001;

    multi_cycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func3      (func3),
        .func7      (func7),
        .zero       (zero),
        .LSB        (LSB),
        .PCWrite    (PCWrite),
        .adrSrc     (adrSrc),
        .IRWrite    (IRWrite),
        .regWrite   (regWrite),
        .memWrite   (memWrite),
        .ALUControl (ALUControl),
        .immSrc     (immSrc),
        .resultSrc  (resultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign got = {PCWrite, adrSrc, IRWrite, regWrite, memWrite, ALUControl,
                  immSrc, resultSrc, ALUSrcA, ALUSrcB, illegal};

    // Instruction kinds: 0 R, 1 I-ALU, 2 lw, 3 sw, 4 branch, 5 jal, 6 jalr, 7 lui, 8 illegal
    function automatic int kind(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        case (o)
            7'b0110011: return (f3 inside {3'd0, 3'd7, 3'd6, 3'd4, 3'd2}) &&
                               (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0)) ? 0 : 8;
            7'b0010011: return (f3 inside {3'd0, 3'd7, 3'd6, 3'd4, 3'd2}) ? 1 : 8;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return (f3 inside {3'd0, 3'd1, 3'd4, 3'd5}) ? 4 : 8;
            7'b1101111: return 5;
            7'b1100111: return 6;
            7'b0110111: return 7;
            default:    return 8;
        endcase
    endfunction

    function automatic int n_cycles(input int k);
        case (k)
            2:       return 5;
            4, 7:    return 3;
            8:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 3'd1 : 3'd0;
            3'd7:    return 3'd2;
            3'd6:    return 3'd3;
            3'd4:    return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b0110111: return 3'd3;
            7'b1101111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            default: return !l;
        endcase
    endfunction

    // Expected output vector for cycle s of an instruction (s=0 is FETCH)
    function automatic logic [17:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic z, input logic l, input int s);
        logic pcw, adr, irw, rw, mw, ill;
        logic [2:0] alu;
        logic [1:0] res, sa, sb;
        int k;
        k = kind(o, f3, f7);
        {pcw, adr, irw, rw, mw, ill} = '0;
        alu = 3'd0; res = 2'd0; sa = 2'd0; sb = 2'd0;
        if (s == 0) begin
            irw = 1; pcw = 1; sb = 2; res = 2;
        end else if (s == 1) begin
            sa = 1; sb = 1; ill = (k == 8);
        end else if (k == 2 || k == 3) begin
            if (s == 2) begin sa = 2; sb = 1; end
            else if (s == 3) begin adr = 1; mw = (k == 3); end
            else begin res = 1; rw = 1; end
        end else if (k == 0 || k == 1) begin
            if (s == 2) begin sa = 2; sb = (k == 1) ? 2'd1 : 2'd0; alu = alu_of(f3, k == 0 && f7[5]); end
            else rw = 1;
        end else if (k == 4) begin
            sa = 2; alu = f3[2] ? 3'd5 : 3'd1; pcw = taken(f3, z, l);
        end else if (k == 7) begin
            res = 3; rw = 1;
        end else if (s == 2) begin
            pcw = 1;
            if (k == 6) begin sa = 2; sb = 1; res = 2; end
        end else begin
            sa = 1; sb = 2; res = 2; rw = 1;
        end
        return {pcw, adr, irw, rw, mw, alu, imm_of(o), res, sa, sb, ill};
    endfunction

    task automatic chk(input string nm, input logic [17:0] g, input logic [17:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h", nm, g, e);
        end
    endtask

    // Runs one instruction from its FETCH cycle; optional literal probe and mid-instruction reset
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic l, input string nm,
                       input int ps, input logic [17:0] pm, input logic [17:0] pv, input int abort_at);
        int n;
        op = o; func3 = f3; func7 = f7; zero = z; LSB = l;
        n = n_cycles(kind(o, f3, f7));
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d", nm, s), got, model(o, f3, f7, z, l, s));
            if (s == ps) chk($sformatf("%s_lit%0d", nm, s), got & pm, pv);
            if (s == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk($sformatf("%s_async_rst", nm), got, 18'h0);
                @(posedge clk); #1 chk($sformatf("%s_rst_held", nm), got, 18'h0);
                @(posedge clk); #1 rst_n = 1'b1;
                @(negedge clk); chk($sformatf("%s_init", nm), got, 18'h0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; op = 7'h33; func3 = 3'd0; func7 = 7'd0; zero = 1'b0; LSB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk($sformatf("reset_%0d", i), got, 18'h0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("init_after_release", got, 18'h0);
        @(posedge clk); #1;
        run(7'b0110011, 3'd0, 7'h20, 0, 0, "r_sub",   0, PCW | IRW | SB, 18'h28004, -1);
        run(7'b0110011, 3'd0, 7'h20, 0, 0, "r_sub2",  2, ALU, 18'h00400, -1);
        run(7'b0110011, 3'd7, 7'h00, 1, 1, "r_and",  -1, 18'h0, 18'h0, -1);
        run(7'b0010011, 3'd4, 7'h55, 0, 1, "xori",   -1, 18'h0, 18'h0, -1);
        run(7'b0010011, 3'd2, 7'h20, 1, 0, "slti",   -1, 18'h0, 18'h0, -1);
        run(7'b0000011, 3'd2, 7'h00, 0, 0, "lw_rd",   3, ADR, ADR, -1);
        run(7'b0000011, 3'd2, 7'h00, 1, 1, "lw_wb",   4, RES | RW, 18'h04020, -1);
        run(7'b0100011, 3'd2, 7'h00, 0, 0, "sw",      3, MW | RW, MW, -1);
        run(7'b1100011, 3'd1, 7'h00, 1, 0, "bne_z1",  2, PCW, 18'h0, -1);
        run(7'b1100011, 3'd1, 7'h00, 0, 0, "bne_z0",  2, PCW, PCW, -1);
        run(7'b1100011, 3'd5, 7'h00, 0, 0, "bge_l0",  2, PCW, PCW, -1);
        run(7'b1100011, 3'd4, 7'h00, 0, 1, "blt_l1",  2, PCW | ALU, PCW | 18'h01400, -1);
        run(7'b1100011, 3'd0, 7'h00, 0, 1, "beq_z0", -1, 18'h0, 18'h0, -1);
        run(7'b1101111, 3'd0, 7'h00, 0, 0, "jal",     2, PCW | RES, PCW, -1);
        run(7'b1101111, 3'd0, 7'h00, 0, 0, "jal_lnk", 3, RW | RES, 18'h04040, -1);
        run(7'b1100111, 3'd0, 7'h00, 1, 1, "jalr",   -1, 18'h0, 18'h0, -1);
        run(7'b0110111, 3'd0, 7'h00, 0, 0, "lui",     2, RES | IMM, 18'h001E0, -1);
        run(7'b1111111, 3'd0, 7'h00, 0, 0, "bad_op",  1, ILL | RW | MW, ILL, -1);
        run(7'b1100011, 3'd2, 7'h00, 0, 0, "bad_br",  1, ILL, ILL, -1);
        run(7'b0110011, 3'd7, 7'h20, 0, 0, "bad_f7",  1, ILL, ILL, -1);
        run(7'b0000011, 3'd2, 7'h00, 0, 0, "lw_abort", 3, ADR, ADR, 3);
        run(7'b0110011, 3'd6, 7'h00, 0, 0, "r_or",    0, PCW | IRW | SB, 18'h28004, -1);
        run(7'b0010011, 3'd0, 7'h00, 0, 0, "addi",   -1, 18'h0, 18'h0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
